// File: rtl/vip_pkg.sv
// Shared constants for the vip_adapt_bin video binarization slice: mode encoding,
// luma coefficients, default threshold and the video timing bundle.
package vip_pkg;
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GRAY   = 2'd1;
  localparam logic [1:0] MODE_BIN    = 2'd2;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  localparam logic [7:0] THRESH_DEFAULT = 8'd128;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } timing_t;
endpackage

// File: rtl/vip_mean_div.sv
// Restoring divider producing an 8-bit quotient in 8 steps (one per cycle, the first on the
// start cycle). The caller guarantees dividend < 256*divisor so the quotient fits 8 bits.
module vip_mean_div #(
  parameter int DIVISOR_W = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIVISOR_W+7:0]   dividend,
  input  logic [DIVISOR_W-1:0]   divisor,
  output logic                   busy,
  output logic [7:0]             quotient,
  output logic                   done
);
  localparam int DW = DIVISOR_W + 8;

  logic [DW-1:0] rem, ds, cur_rem, cur_ds, nxt_rem;
  logic [2:0]    cnt;
  logic          load, take;

  // A start while busy is ignored; the running division keeps its operands.
  assign load    = start && !busy;
  assign cur_rem = load ? dividend : rem;
  assign cur_ds  = load ? {1'b0, divisor, 7'b0} : ds;
  assign take    = (cur_rem >= cur_ds);
  assign nxt_rem = take ? (cur_rem - cur_ds) : cur_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= 3'd0;
      rem      <= '0;
      ds       <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (load || busy) begin
        rem      <= nxt_rem;
        ds       <= cur_ds >> 1;
        quotient <= {quotient[6:0], take};
        cnt      <= load ? 3'd1 : cnt + 3'd1;
        busy     <= load || (cnt != 3'd7);
        done     <= busy && (cnt == 3'd7);
      end
    end
  end
endmodule

// File: rtl/vip_adapt_bin.sv
// RGB888 -> luma -> binary video pipeline, 4-cycle latency on data and timing.
// VIP_AUTO_THRESH_EN adds the per-frame luma mean (accumulator + vip_mean_div) used as auto threshold.
module vip_adapt_bin
  import vip_pkg::*;
#(
  parameter int         PIX_CNT_W  = 22,
  parameter logic [7:0] THRESH_DEF = THRESH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_hsync,
  input  logic        pre_frame_de,
  input  logic [23:0] pre_rgb,
  input  logic [1:0]  mode,
  input  logic        auto_en,
  input  logic [7:0]  thresh_manual,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [23:0] post_rgb,
  output logic        monoc,
  output logic        monoc_fall,
  output logic [7:0]  frame_mean,
  output logic        mean_valid
);
  timing_t     tim_in, tim1, tim2, tim3;
  logic [15:0] prod_r, prod_g, prod_b, luma_sum;
  logic [23:0] rgb1, rgb2, rgb3, rgb_n;
  logic [1:0]  mode1, mode2, mode3;
  logic [7:0]  y3, thr_active, thr_man;
  logic        vs_prev, vs_rise, monoc_n;

  assign tim_in  = {pre_frame_vsync, pre_frame_hsync, pre_frame_de};
  assign vs_rise = pre_frame_vsync && !vs_prev;

  // Mode travels with its pixel so a mid-frame change applies from the next input pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      tim1 <= '0; tim2 <= '0; tim3 <= '0;
      rgb1 <= '0; rgb2 <= '0; rgb3 <= '0;
      mode1 <= '0; mode2 <= '0; mode3 <= '0;
      prod_r <= '0; prod_g <= '0; prod_b <= '0;
      luma_sum <= '0;
      y3 <= '0;
    end else begin
      tim1   <= tim_in;
      rgb1   <= pre_rgb;
      mode1  <= mode;
      prod_r <= 16'(pre_rgb[23:16]) * 16'(COEF_R);
      prod_g <= 16'(pre_rgb[15:8]) * 16'(COEF_G);
      prod_b <= 16'(pre_rgb[7:0]) * 16'(COEF_B);
      tim2     <= tim1;
      rgb2     <= rgb1;
      mode2    <= mode1;
      luma_sum <= prod_r + prod_g + prod_b;
      tim3  <= tim2;
      rgb3  <= rgb2;
      mode3 <= mode2;
      y3    <= 8'(luma_sum >> 8);
    end
  end

  always_comb begin
    monoc_n = tim3.de && (y3 > thr_active);
    rgb_n   = '0;
    if (tim3.de) begin
      case (mode3)
        MODE_BYPASS: rgb_n = rgb3;
        MODE_GRAY:   rgb_n = {y3, y3, y3};
        MODE_BIN:    rgb_n = {24{monoc_n}};
        default:     rgb_n = {24{monoc_n}};
      endcase
    end
  end

  // A fall needs the previous stage-4 pixel to be de-high, so a line start never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de    <= 1'b0;
      post_rgb         <= '0;
      monoc            <= 1'b0;
      monoc_fall       <= 1'b0;
      vs_prev          <= 1'b0;
      thr_man          <= THRESH_DEF;
    end else begin
      post_frame_vsync <= tim3.vsync;
      post_frame_hsync <= tim3.hsync;
      post_frame_de    <= tim3.de;
      post_rgb         <= rgb_n;
      monoc            <= monoc_n;
      monoc_fall       <= tim3.de && post_frame_de && monoc && !monoc_n;
      vs_prev          <= pre_frame_vsync;
      if (vs_rise) thr_man <= thresh_manual;
    end
  end

`ifdef VIP_AUTO_THRESH_EN
  localparam int SUM_W = PIX_CNT_W + 8;

  logic [SUM_W-1:0]     acc_sum;
  logic [PIX_CNT_W-1:0] acc_cnt;
  logic [7:0]           auto_thresh, mean_q, div_q;
  logic                 sel_auto, mean_new, mean_valid_q, div_start, div_busy, div_done;

  assign div_start = vs_rise && (acc_cnt != '0) && !div_busy;

  vip_mean_div #(.DIVISOR_W(PIX_CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_sum),
    .divisor  (acc_cnt),
    .busy     (div_busy),
    .quotient (div_q),
    .done     (div_done)
  );

  // A finished mean is held pending until the next frame start promotes it to auto_thresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sum      <= '0;
      acc_cnt      <= '0;
      auto_thresh  <= THRESH_DEF;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      mean_new     <= 1'b0;
      sel_auto     <= 1'b0;
    end else begin
      mean_valid_q <= div_done;
      if (div_done) begin
        mean_q   <= div_q;
        mean_new <= 1'b1;
      end else if (vs_rise) begin
        mean_new <= 1'b0;
      end
      if (vs_rise) begin
        sel_auto <= auto_en;
        if (mean_new) auto_thresh <= mean_q;
        acc_sum <= '0;
        acc_cnt <= '0;
      end else if (tim3.de && (acc_cnt != '1)) begin
        acc_sum <= acc_sum + SUM_W'(y3);
        acc_cnt <= acc_cnt + PIX_CNT_W'(1);
      end
    end
  end

  assign thr_active = sel_auto ? auto_thresh : thr_man;
  assign frame_mean = mean_q;
  assign mean_valid = mean_valid_q;
`else
  logic unused_auto_en;

  assign unused_auto_en = auto_en;
  assign thr_active     = thr_man;
  assign frame_mean     = '0;
  assign mean_valid     = 1'b0;
`endif
endmodule

// File: tb/tb_vip_adapt_bin.sv
// Directed-vector bench for vip_adapt_bin; auto-threshold scenarios follow VIP_AUTO_THRESH_EN.
module tb_vip_adapt_bin;
  logic        clk = 1'b0;
  logic        rst;
  logic        pre_frame_vsync, pre_frame_hsync, pre_frame_de;
  logic [23:0] pre_rgb;
  logic [1:0]  mode;
  logic        auto_en;
  logic [7:0]  thresh_manual;
  logic        post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [23:0] post_rgb;
  logic        monoc, monoc_fall;
  logic [7:0]  frame_mean;
  logic        mean_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vip_adapt_bin dut (
    .clk              (clk),
    .rst              (rst),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_hsync  (pre_frame_hsync),
    .pre_frame_de     (pre_frame_de),
    .pre_rgb          (pre_rgb),
    .mode             (mode),
    .auto_en          (auto_en),
    .thresh_manual    (thresh_manual),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_hsync (post_frame_hsync),
    .post_frame_de    (post_frame_de),
    .post_rgb         (post_rgb),
    .monoc            (monoc),
    .monoc_fall       (monoc_fall),
    .frame_mean       (frame_mean),
    .mean_valid       (mean_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input logic [23:0] rgb);
    pre_frame_de    = de;
    pre_frame_hsync = de;
    pre_rgb         = de ? rgb : 24'h0;
  endtask

  task automatic vsync_pulse();
    pre_frame_vsync = 1'b1;
    step();
    pre_frame_vsync = 1'b0;
    step();
  endtask

  // Two-pixel line at threshold boundary: expects monoc 1 then 0 and a fall on the second.
  task automatic line_pair(input string tag, input logic [7:0] y_hi, input logic [7:0] y_lo);
    logic [7:0] ys [2];
    logic       em [2];
    logic       ef [2];
    ys = '{y_hi, y_lo};
    em = '{1'b1, 1'b0};
    ef = '{1'b0, 1'b1};
    mode = 2'd2;
    for (int n = 0; n < 6; n++) begin
      if (n < 2) drive(1'b1, {ys[n], ys[n], ys[n]}); else drive(1'b0, 24'h0);
      step();
      if (n >= 3 && n < 5) begin
        n_cmp++;
        if (monoc !== em[n-3]) begin
          n_err++;
          $display("FAIL %s_monoc[%0d]: got %b expected %b", tag, n-3, monoc, em[n-3]);
        end
        n_cmp++;
        if (monoc_fall !== ef[n-3]) begin
          n_err++;
          $display("FAIL %s_fall[%0d]: got %b expected %b", tag, n-3, monoc_fall, ef[n-3]);
        end
      end
    end
  endtask

  task automatic test_reset();
    pre_frame_vsync = 1'b0;
    drive(1'b0, 24'h0);
    mode = 2'd1;
    auto_en = 1'b0;
    thresh_manual = 8'd128;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb, monoc, monoc_fall, mean_valid} !== 30'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb, monoc, monoc_fall, mean_valid});
    end
    n_cmp++;
    if (frame_mean !== 8'd0) begin
      n_err++;
      $display("FAIL reset_frame_mean: got %0d expected 0", frame_mean);
    end
    // Threshold after reset is the default 128
    line_pair("reset_thresh", 8'd129, 8'd128);
  endtask

  task automatic test_latency();
    mode = 2'd1;
    for (int n = 0; n < 8; n++) begin
      pre_frame_vsync = (n == 0);
      if (n == 0) drive(1'b1, 24'h808080); else drive(1'b0, 24'h0);
      step();
      n_cmp++;
      if ({post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb} !== ((n == 3) ? 27'h7808080 : 27'h0)) begin
        n_err++;
        $display("FAIL latency[%0d]: got %h expected %h", n,
                 {post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb}, (n == 3) ? 27'h7808080 : 27'h0);
      end
    end
    pre_frame_vsync = 1'b0;
  endtask

  task automatic test_modes();
    logic [23:0] pix [8];
    logic [1:0]  md  [8];
    logic [23:0] exp_rgb [8];
    pix     = '{24'h123456, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hABCDEF, 24'hFFFFFF, 24'hFFFFFF, 24'h101010};
    md      = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_rgb = '{24'h123456, 24'h4C4C4C, 24'h959595, 24'h1C1C1C, 24'hABCDEF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    for (int n = 0; n < 12; n++) begin
      if (n < 8) begin
        mode = md[n];
        drive(1'b1, pix[n]);
      end else begin
        drive(1'b0, 24'h0);
      end
      step();
      if (n >= 3 && n < 11) begin
        n_cmp++;
        if ({post_frame_de, post_rgb} !== {1'b1, exp_rgb[n-3]}) begin
          n_err++;
          $display("FAIL modes[%0d]: got de=%b rgb=%h expected de=1 rgb=%h", n-3, post_frame_de, post_rgb, exp_rgb[n-3]);
        end
      end
    end
  endtask

  task automatic test_binary();
    logic        de [8];
    logic [7:0]  ys [8];
    logic        em [8];
    logic        ef [8];
    thresh_manual = 8'd100;
    vsync_pulse();
    // Mid-frame change must not reach the comparator
    thresh_manual = 8'd0;
    mode = 2'd2;
    de = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ys = '{8'd101, 8'd100, 8'd0, 8'd50, 8'd200, 8'd0, 8'd100, 8'd101};
    em = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ef = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 12; n++) begin
      if (n < 8) drive(de[n], {ys[n], ys[n], ys[n]}); else drive(1'b0, 24'h0);
      step();
      if (n >= 3 && n < 11) begin
        n_cmp++;
        if ({monoc, monoc_fall} !== {em[n-3], ef[n-3]}) begin
          n_err++;
          $display("FAIL binary[%0d]: got monoc=%b fall=%b expected monoc=%b fall=%b",
                   n-3, monoc, monoc_fall, em[n-3], ef[n-3]);
        end
        n_cmp++;
        if (post_rgb !== (em[n-3] ? 24'hFFFFFF : 24'h000000)) begin
          n_err++;
          $display("FAIL binary_rgb[%0d]: got %h expected %h", n-3, post_rgb, em[n-3] ? 24'hFFFFFF : 24'h000000);
        end
      end
    end
  endtask

`ifdef VIP_AUTO_THRESH_EN
  task automatic test_auto_mean();
    rst = 1'b1;
    step();
    rst = 1'b0;
    auto_en = 1'b1;
    mode = 2'd2;
    vsync_pulse();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 24'h3C3C3C);
      step();
    end
    drive(1'b0, 24'h0);
    repeat (6) step();
    pre_frame_vsync = 1'b1;
    step();
    pre_frame_vsync = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      n_cmp++;
      if (mean_valid !== (i == 8)) begin
        n_err++;
        $display("FAIL mean_valid_t%0d: got %b expected %b", i, mean_valid, (i == 8));
      end
      if (i == 8) begin
        n_cmp++;
        if (frame_mean !== 8'd60) begin
          n_err++;
          $display("FAIL frame_mean: got %0d expected 60", frame_mean);
        end
      end
    end
    repeat (3) step();
    // Empty frame ends here: no division, mean kept, 60 becomes the threshold
    pre_frame_vsync = 1'b1;
    step();
    pre_frame_vsync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (mean_valid !== 1'b0) begin
        n_err++;
        $display("FAIL empty_mean_valid_t%0d: got %b expected 0", i, mean_valid);
      end
    end
    n_cmp++;
    if (frame_mean !== 8'd60) begin
      n_err++;
      $display("FAIL empty_frame_mean: got %0d expected 60", frame_mean);
    end
    line_pair("auto_thresh", 8'd61, 8'd60);
  endtask

  task automatic test_reset_div();
    auto_en = 1'b1;
    vsync_pulse();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 24'hC8C8C8);
      step();
    end
    drive(1'b0, 24'h0);
    repeat (6) step();
    pre_frame_vsync = 1'b1;
    step();
    pre_frame_vsync = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({mean_valid, frame_mean} !== 9'h0) begin
        n_err++;
        $display("FAIL rst_div_t%0d: got valid=%b mean=%0d expected valid=0 mean=0", i, mean_valid, frame_mean);
      end
    end
    line_pair("rst_div_thresh", 8'd129, 8'd128);
  endtask
`else
  task automatic test_no_auto();
    auto_en = 1'b1;
    thresh_manual = 8'd50;
    vsync_pulse();
    line_pair("manual_only", 8'd51, 8'd50);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 24'h404040);
      step();
    end
    drive(1'b0, 24'h0);
    repeat (4) step();
    pre_frame_vsync = 1'b1;
    step();
    pre_frame_vsync = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if ({mean_valid, frame_mean} !== 9'h0) begin
        n_err++;
        $display("FAIL no_auto_t%0d: got valid=%b mean=%0d expected valid=0 mean=0", i, mean_valid, frame_mean);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_binary();
`ifdef VIP_AUTO_THRESH_EN
    test_auto_mean();
    test_reset_div();
`else
    test_no_auto();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
